// File: rtl/sram_bank_pkg.sv
// Shared definitions for the sram_bank storage block: bus widths, defaults,
// FSM state codes and parameter legality helpers.
package sram_bank_pkg;

  localparam int DATA_BUS_W  = 32;
  localparam int REG_BUS_W   = 32;
  localparam int MEM_NUM_DEF = 4096;

  localparam logic [DATA_BUS_W-1:0] ZERO_WORD = '0;

  typedef logic [0:0] state_t;

  // Zero-fill in progress vs. normal operation.
  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_RUN   = 1'b1;

  // Only one- and two-cycle read latencies are implemented.
  function automatic bit rd_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  // Data width must be whole bytes, at most 64 bits.
  function automatic bit dw_ok(input int dw);
    return (dw >= 8) && (dw <= 64) && ((dw % 8) == 0);
  endfunction

endpackage

// File: rtl/sram_bank_if.sv
// Request/response bus between a core (fetch or LSU) and sram_bank.
//
// Handshake: there is no ready. A request (wen or ren high) is taken in every
// cycle where busy is low and is silently ignored while busy is high. A read
// accepted in cycle t answers with r_valid in cycle t+RD_LAT; r_valid is a
// one-cycle qualifier with no backpressure, so the master must accept every
// response. err is a one-cycle pulse flagging an out-of-range access.
interface sram_bank_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic            wen;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;
  logic [DW/8-1:0] w_strb;
  logic            ren;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_data;
  logic            r_valid;
  logic            busy;
  logic            err;

  modport master (
    output wen, w_addr, w_data, w_strb, ren, r_addr,
    input  r_data, r_valid, busy, err
  );

  modport slave (
    input  wen, w_addr, w_data, w_strb, ren, r_addr,
    output r_data, r_valid, busy, err
  );
endinterface

// File: rtl/sram_core.sv
// Storage array: one write port with per-byte enables and one registered
// read port. Read returns the contents before a same-edge write.
module sram_core #(
  parameter int DW    = 32,
  parameter int DEPTH = 4096,
  parameter int IW    = 12
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [IW-1:0]   w_idx_i,
  input  logic [DW-1:0]   w_data_i,
  input  logic [DW/8-1:0] w_be_i,
  input  logic            re_i,
  input  logic [IW-1:0]   r_idx_i,
  output logic [DW-1:0]   r_data_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Byte-masked write of the addressed word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < DW / 8; b++) begin
        if (w_be_i[b]) begin
          mem_q[w_idx_i][8*b +: 8] <= w_data_i[8*b +: 8];
        end
      end
    end
  end

  // Registered read; output holds when no read is requested.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[r_idx_i];
    end
  end

  assign r_data_o = rdata_q;

endmodule

// File: rtl/sram_bank.sv
// Byte-addressed, word-organised SRAM bank with byte strobes, 1- or 2-cycle
// pipelined reads, write-first forwarding, out-of-range flagging and an
// optional post-reset zero-fill sweep.
module sram_bank
  import sram_bank_pkg::*;
#(
  parameter int DW         = DATA_BUS_W,
  parameter int AW         = REG_BUS_W,
  parameter int MEM_NUM    = MEM_NUM_DEF,
  parameter int RD_LAT     = 1,
  parameter int CLR_ON_RST = 1
) (
  input  logic       clk,
  input  logic       rst,
  sram_bank_if.slave bus,
  output state_t     state_o
);

  localparam int NB   = DW / 8;
  localparam int OFFW = (NB > 1) ? $clog2(NB) : 0;
  localparam int IW   = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;

  localparam state_t RST_STATE = (CLR_ON_RST != 0) ? ST_CLEAR : ST_RUN;

  if (!rd_lat_ok(RD_LAT) || !dw_ok(DW)) begin : g_param_check
    $error("sram_bank: RD_LAT must be 1 or 2 and DW a multiple of 8 up to 64");
  end

  state_t        state_q, state_d;
  logic [IW-1:0] clr_idx_q, clr_idx_d;

  logic          in_clear, in_run;
  logic [AW-1:0] w_idx_full, r_idx_full;
  logic          w_oor, r_oor;
  logic          w_fire, w_ok, w_bad;
  logic          r_fire, r_ok, r_bad;
  logic          fwd_hit;
  logic [DW-1:0] wmask;

  logic          core_we;
  logic [IW-1:0] core_widx;
  logic [DW-1:0] core_wdata;
  logic [NB-1:0] core_be;
  logic [DW-1:0] core_rdata;

  logic          s1_valid_q, s1_oor_q;
  logic [DW-1:0] s1_mask_q, s1_wdata_q, s1_data;

  logic          out_valid, out_rerr;
  logic [DW-1:0] out_data;
  logic [DW-1:0] hold_q;
  logic          w_err_q;

  assign in_clear = (state_q == ST_CLEAR);
  assign in_run   = (state_q == ST_RUN);

  // Byte offset bits are dropped; the whole remaining index is range checked
  // so high addresses never alias onto real words.
  assign w_idx_full = bus.w_addr >> OFFW;
  assign r_idx_full = bus.r_addr >> OFFW;
  assign w_oor      = (w_idx_full >= AW'(MEM_NUM));
  assign r_oor      = (r_idx_full >= AW'(MEM_NUM));

  assign w_fire = in_run && bus.wen && !rst;
  assign w_ok   = w_fire && !w_oor;
  assign w_bad  = w_fire && w_oor;
  assign r_fire = in_run && bus.ren && !rst;
  assign r_ok   = r_fire && !r_oor;
  assign r_bad  = r_fire && r_oor;

  // Expand byte strobes to a bit mask for same-cycle forwarding.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < NB; b++) begin
      wmask[8*b +: 8] = {8{bus.w_strb[b]}};
    end
  end

  assign fwd_hit = w_ok && r_ok && (w_idx_full == r_idx_full);

  // Zero-fill sweep: one word per cycle, then fall into normal operation.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (in_clear) begin
      if (clr_idx_q == IW'(MEM_NUM - 1)) begin
        state_d   = ST_RUN;
        clr_idx_d = '0;
      end else begin
        clr_idx_d = clr_idx_q + IW'(1);
      end
    end
  end

  // FSM state register; reset restarts the sweep from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RST_STATE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // The sweep owns the write port while clearing.
  assign core_we    = (in_clear && !rst) || w_ok;
  assign core_widx  = in_clear ? clr_idx_q : w_idx_full[IW-1:0];
  assign core_wdata = in_clear ? DW'(ZERO_WORD) : bus.w_data;
  assign core_be    = in_clear ? '1 : bus.w_strb;

  sram_core #(
    .DW   (DW),
    .DEPTH(MEM_NUM),
    .IW   (IW)
  ) u_core (
    .clk     (clk),
    .we_i    (core_we),
    .w_idx_i (core_widx),
    .w_data_i(core_wdata),
    .w_be_i  (core_be),
    .re_i    (r_ok),
    .r_idx_i (r_idx_full[IW-1:0]),
    .r_data_o(core_rdata)
  );

  // First read stage: remember range result and any same-cycle write bytes,
  // since the array read returns pre-write contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= r_fire;
    end
    if (r_fire) begin
      s1_oor_q   <= r_bad;
      s1_mask_q  <= fwd_hit ? wmask : '0;
      s1_wdata_q <= bus.w_data;
    end
  end

  assign s1_data = s1_oor_q ? '0
                 : ((core_rdata & ~s1_mask_q) | (s1_wdata_q & s1_mask_q));

  if (RD_LAT == 2) begin : g_lat2
    logic          s2_valid_q, s2_err_q;
    logic [DW-1:0] s2_data_q;

    // Second read stage; data is frozen here so later writes cannot alter it.
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_err_q   <= 1'b0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_err_q   <= s1_valid_q && s1_oor_q;
      end
      s2_data_q <= s1_data;
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_rerr  = s2_err_q;
  end else begin : g_lat1
    assign out_valid = s1_valid_q;
    assign out_data  = s1_data;
    assign out_rerr  = s1_valid_q && s1_oor_q;
  end

  // Keep the last response so r_data is stable while r_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else if (out_valid) begin
      hold_q <= out_data;
    end
  end

  // Dropped out-of-range write reports one cycle after the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_err_q <= 1'b0;
    end else begin
      w_err_q <= w_bad;
    end
  end

  assign bus.r_data  = out_valid ? out_data : hold_q;
  assign bus.r_valid = out_valid;
  assign bus.err     = w_err_q || out_rerr;
  assign bus.busy    = in_clear;
  assign state_o     = state_q;

endmodule

// File: tb/tb_sram_bank.sv
// Bench for sram_bank: two instances (16 words / latency 1 and 4096 words /
// latency 2) share one stimulus stream and are each compared every cycle
// against a word-array reference model with an expected-response queue.
module tb_sram_bank;

  localparam int NUM_A = 16;
  localparam int NUM_B = 4096;
  localparam int LAT_A = 1;
  localparam int LAT_B = 2;
  localparam int W     = 65;  // {due cycle[31:0], err, data[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        wen = 1'b0;
  logic [31:0] w_addr = '0;
  logic [31:0] w_data = '0;
  logic [3:0]  w_strb = '0;
  logic        ren = 1'b0;
  logic [31:0] r_addr = '0;
  logic [0:0]  state_a, state_b;

  sram_bank_if #(.DW(32), .AW(32)) bus_a ();
  sram_bank_if #(.DW(32), .AW(32)) bus_b ();

  assign bus_a.wen = wen;   assign bus_b.wen = wen;
  assign bus_a.w_addr = w_addr; assign bus_b.w_addr = w_addr;
  assign bus_a.w_data = w_data; assign bus_b.w_data = w_data;
  assign bus_a.w_strb = w_strb; assign bus_b.w_strb = w_strb;
  assign bus_a.ren = ren;   assign bus_b.ren = ren;
  assign bus_a.r_addr = r_addr; assign bus_b.r_addr = r_addr;

  sram_bank #(.DW(32), .AW(32), .MEM_NUM(NUM_A), .RD_LAT(LAT_A), .CLR_ON_RST(1)) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave), .state_o(state_a)
  );

  sram_bank #(.DW(32), .AW(32), .MEM_NUM(NUM_B), .RD_LAT(LAT_B), .CLR_ON_RST(1)) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave), .state_o(state_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  logic [31:0]  mem [2][NUM_B];
  int           busy_left [2];
  logic         exp_v [2];
  logic         exp_e [2];
  logic [31:0]  exp_rd [2];
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  int           cyc = 0;

  function automatic int num_of(input int k);
    return (k == 0) ? NUM_A : NUM_B;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT_A : LAT_B;
  endfunction

  // Reference behaviour of one instance for the edge that starts cycle `cyc`.
  task automatic model_edge(input int k);
    logic [31:0]  widx, ridx;
    logic [W-1:0] ent;
    logic         werr;
    int           due;
    werr = 1'b0;
    exp_v[k] = 1'b0;
    if (rst) begin
      busy_left[k] = num_of(k);
      if (k == 0) exp_q_a.delete(); else exp_q_b.delete();
      exp_rd[k] = '0;
      exp_e[k] = 1'b0;
      for (int i = 0; i < NUM_B; i++) mem[k][i] = '0;
    end else begin
      if (busy_left[k] > 0) begin
        busy_left[k]--;
      end else begin
        if (wen) begin
          widx = w_addr >> 2;
          if (widx >= 32'(num_of(k))) werr = 1'b1;
          else for (int b = 0; b < 4; b++)
            if (w_strb[b]) mem[k][widx[11:0]][8*b +: 8] = w_data[8*b +: 8];
        end
        if (ren) begin
          ridx = r_addr >> 2;
          due = cyc - 1 + lat_of(k);
          if (ridx >= 32'(num_of(k))) ent = {32'(due), 1'b1, 32'h0};
          else ent = {32'(due), 1'b0, mem[k][ridx[11:0]]};
          if (k == 0) exp_q_a.push_back(ent); else exp_q_b.push_back(ent);
        end
      end
      exp_e[k] = werr;
      if (k == 0 && exp_q_a.size() > 0) begin
        ent = exp_q_a[0];
        if (int'(ent[64:33]) == cyc) begin
          void'(exp_q_a.pop_front());
          exp_v[k] = 1'b1; exp_rd[k] = ent[31:0]; exp_e[k] = werr | ent[32];
        end
      end
      if (k == 1 && exp_q_b.size() > 0) begin
        ent = exp_q_b[0];
        if (int'(ent[64:33]) == cyc) begin
          void'(exp_q_b.pop_front());
          exp_v[k] = 1'b1; exp_rd[k] = ent[31:0]; exp_e[k] = werr | ent[32];
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("busy_a", bus_a.busy, busy_left[0] > 0);
    chk("valid_a", bus_a.r_valid, exp_v[0]);
    chk("err_a", bus_a.err, exp_e[0]);
    chk("rdata_a", bus_a.r_data, exp_rd[0]);
    chk("busy_b", bus_b.busy, busy_left[1] > 0);
    chk("valid_b", bus_b.r_valid, exp_v[1]);
    chk("err_b", bus_b.err, exp_e[1]);
    chk("rdata_b", bus_b.r_data, exp_rd[1]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge(0);
    model_edge(1);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic wait_clear(input int exp_a, input int exp_b);
    int cnt_a, cnt_b;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 6000; i++) begin
      if (bus_a.busy) cnt_a++;
      if (bus_b.busy) cnt_b++;
      if (!bus_a.busy && !bus_b.busy) break;
      step();
    end
    chk("clear_len_a", cnt_a, exp_a);
    chk("clear_len_b", cnt_b, exp_b);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wen = 1'b1; w_addr = a; w_data = d; w_strb = s;
    step();
    wen = 1'b0;
  endtask

  // Read (with any write the caller has already set up) and check both
  // instances at their own latency against fixed expected values.
  task automatic read_both(input logic [31:0] a, input logic [31:0] da, input logic ea,
                           input logic [31:0] db, input logic eb);
    ren = 1'b1; r_addr = a;
    step();
    ren = 1'b0; wen = 1'b0;
    chk("rd_valid_a", bus_a.r_valid, 1'b1);
    chk("rd_data_a", bus_a.r_data, da);
    chk("rd_err_a", bus_a.err, ea);
    chk("rd_early_b", bus_b.r_valid, 1'b0);
    step();
    chk("rd_valid_b", bus_b.r_valid, 1'b1);
    chk("rd_data_b", bus_b.r_data, db);
    chk("rd_err_b", bus_b.err, eb);
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 6) return 32'(($urandom_range(0, 19) << 2) | $urandom_range(0, 3));
    else if (sel < 8) return 32'h0000_3FF0 + 32'($urandom_range(0, 31));
    else if (sel == 8) return 32'h0000_0038 + 32'($urandom_range(0, 15));
    else return $urandom;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    do_reset();
    wait_clear(NUM_A, NUM_B);

    // Cleared contents; 0x3C is the last word of the small instance.
    read_both(32'h0000_003C, 32'h0, 1'b0, 32'h0, 1'b0);

    // Byte strobes.
    wr(32'h10, 32'hAABB_CCDD, 4'b1111);
    wr(32'h10, 32'h1122_3344, 4'b0101);
    read_both(32'h10, 32'hAA22_CC44, 1'b0, 32'hAA22_CC44, 1'b0);

    // Same-cycle write and read: write-first on strobed bytes.
    wen = 1'b1; w_addr = 32'h20; w_data = 32'hFFFF_FFFF; w_strb = 4'b0011;
    read_both(32'h20, 32'h0000_FFFF, 1'b0, 32'h0000_FFFF, 1'b0);

    // Out of range write: err pulse next cycle, nothing stored.
    wr(32'h0000_4000, 32'hDEAD_BEEF, 4'b1111);
    chk("werr_a", bus_a.err, 1'b1);
    chk("werr_b", bus_b.err, 1'b1);
    read_both(32'h0000_4000, 32'h0, 1'b1, 32'h0, 1'b1);
    read_both(32'h0000_3FFC, 32'h0, 1'b1, 32'h0, 1'b0);
    read_both(32'h0000_0000, 32'h0, 1'b0, 32'h0, 1'b0);

    // Write and read both out of range in one cycle.
    wen = 1'b1; w_addr = 32'h0000_8000; w_data = 32'h1234_5678; w_strb = 4'b1111;
    read_both(32'h0000_8000, 32'h0, 1'b1, 32'h0, 1'b1);
    step();
    chk("err_single_a", bus_a.err, 1'b0);

    // Back-to-back reads.
    wr(32'h0, 32'h1111_1111, 4'b1111);
    wr(32'h4, 32'h2222_2222, 4'b1111);
    wr(32'h8, 32'h3333_3333, 4'b1111);
    ren = 1'b1; r_addr = 32'h0;
    step();
    chk("pipe0_a", bus_a.r_data, 32'h1111_1111);
    chk("pipe0_vb", bus_b.r_valid, 1'b0);
    r_addr = 32'h4;
    step();
    chk("pipe1_a", bus_a.r_data, 32'h2222_2222);
    chk("pipe1_vb", bus_b.r_valid, 1'b1);
    chk("pipe1_b", bus_b.r_data, 32'h1111_1111);
    r_addr = 32'h8;
    step();
    ren = 1'b0;
    chk("pipe2_a", bus_a.r_data, 32'h3333_3333);
    chk("pipe2_vb", bus_b.r_valid, 1'b1);
    chk("pipe2_b", bus_b.r_data, 32'h2222_2222);
    step();
    chk("pipe3_va", bus_a.r_valid, 1'b0);
    chk("pipe3_vb", bus_b.r_valid, 1'b1);
    chk("pipe3_b", bus_b.r_data, 32'h3333_3333);
    step();
    chk("pipe4_vb", bus_b.r_valid, 1'b0);
    chk("pipe4_hold_b", bus_b.r_data, 32'h3333_3333);

    // Randomised traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      wen    = 1'($urandom_range(0, 1));
      ren    = 1'($urandom_range(0, 1));
      w_addr = rand_addr();
      r_addr = ($urandom_range(0, 3) == 0) ? w_addr : rand_addr();
      w_data = $urandom;
      w_strb = 4'($urandom_range(0, 15));
      step();
    end
    wen = 1'b0;
    ren = 1'b0;
    repeat (3) step();

    // Reset in the middle of the clear sweep (after word 6 is written).
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_clear(NUM_A, NUM_B);
    read_both(32'h10, 32'h0, 1'b0, 32'h0, 1'b0);

    // Reset with a read still in flight on the two-cycle instance.
    wr(32'h10, 32'h1234_5678, 4'b1111);
    ren = 1'b1; r_addr = 32'h10;
    step();
    ren = 1'b0;
    chk("inflight_a", bus_a.r_data, 32'h1234_5678);
    rst = 1'b1;
    step();
    chk("rst_drop_b", bus_b.r_valid, 1'b0);
    chk("rst_rdata_a", bus_a.r_data, 32'h0);
    rst = 1'b0;
    step();
    chk("rst_drop2_b", bus_b.r_valid, 1'b0);
    wait_clear(NUM_A - 1, NUM_B - 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
